// File: rtl/ctr_rq_sched.sv
// Counter-increment request scheduler: edge-captures PINC/MINC per channel, nets opposing requests,
// and issues one fixed-priority grant per MCT at T12_STB (grant visible the clock after the strobe).
module ctr_rq_sched #(
    parameter int NREQ = 8
) (
    input  logic            SIM_CLK,
    input  logic            SIM_RST,
    input  logic            T12_STB,
    input  logic            GOJAM,
    input  logic            INKL,
    input  logic [NREQ-1:0] PINC_RQ,
    input  logic [NREQ-1:0] MINC_RQ,
    output logic [NREQ-1:0] CTR_GNT,
    output logic            CTR_DN,
    output logic            CTR_BUSY,
    output logic [NREQ-1:0] RQ_PEND,
    output logic            RQ_LOST
);

    logic [NREQ-1:0] prev_p_q, prev_m_q;
    logic [NREQ-1:0] pend_up_q, pend_up_d;
    logic [NREQ-1:0] pend_dn_q, pend_dn_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            dn_q, dn_d;
    logic            lost_q, lost_d;
    logic [NREQ-1:0] new_up, new_dn;
    logic            found;

    always_comb begin
        new_up    = PINC_RQ & ~prev_p_q;
        new_dn    = MINC_RQ & ~prev_m_q;
        pend_up_d = pend_up_q;
        pend_dn_d = pend_dn_q;
        gnt_d     = gnt_q;
        dn_d      = dn_q;
        lost_d    = lost_q;
        found     = 1'b0;

        // Selection looks at pending state from the start of the clock, so a
        // request edge arriving with the strobe waits for the next MCT.
        if (T12_STB) begin
            gnt_d = '0;
            dn_d  = 1'b0;
            if (!INKL) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (!found && (pend_up_q[i] | pend_dn_q[i])) begin
                        found        = 1'b1;
                        gnt_d[i]     = 1'b1;
                        dn_d         = pend_dn_q[i];
                        pend_up_d[i] = 1'b0;
                        pend_dn_d[i] = 1'b0;
                    end
                end
            end
        end

        for (int i = 0; i < NREQ; i++) begin
            if (new_up[i] && !new_dn[i]) begin
                if (pend_dn_d[i])
                    pend_dn_d[i] = 1'b0;
                else if (pend_up_d[i])
                    lost_d = 1'b1;
                else
                    pend_up_d[i] = 1'b1;
            end else if (new_dn[i] && !new_up[i]) begin
                if (pend_up_d[i])
                    pend_up_d[i] = 1'b0;
                else if (pend_dn_d[i])
                    lost_d = 1'b1;
                else
                    pend_dn_d[i] = 1'b1;
            end
        end

        if (GOJAM) begin
            pend_up_d = '0;
            pend_dn_d = '0;
            gnt_d     = '0;
            dn_d      = 1'b0;
            lost_d    = lost_q;
        end
    end

    always_ff @(posedge SIM_CLK) begin
        // Edge detectors always track the inputs, so levels held through
        // reset or GOJAM never register as new requests.
        prev_p_q <= PINC_RQ;
        prev_m_q <= MINC_RQ;
        if (SIM_RST) begin
            pend_up_q <= '0;
            pend_dn_q <= '0;
            gnt_q     <= '0;
            dn_q      <= 1'b0;
            lost_q    <= 1'b0;
        end else begin
            pend_up_q <= pend_up_d;
            pend_dn_q <= pend_dn_d;
            gnt_q     <= gnt_d;
            dn_q      <= dn_d;
            lost_q    <= lost_d;
        end
    end

    assign CTR_GNT  = gnt_q;
    assign CTR_DN   = dn_q;
    assign CTR_BUSY = |gnt_q;
    assign RQ_PEND  = pend_up_q | pend_dn_q;
    assign RQ_LOST  = lost_q;

endmodule
